// File: rtl/skeeball_pkg.sv
// skeeball_pkg: shared state encoding, widths and hole point table for the skeeball controller.
package skeeball_pkg;
    localparam int SCORE_W   = 10;
    localparam int BALL_W    = 4;
    localparam int NUM_HOLES = 6;
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_ROLL, S_SCORE, S_DONE} state_t;
    localparam logic [SCORE_W-1:0] HOLE_PTS [NUM_HOLES] = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd100};
    // Points for a set of simultaneous hole edges: the highest-index hole wins, none scores 0.
    function automatic logic [SCORE_W-1:0] hole_points(input logic [NUM_HOLES-1:0] hits);
        logic [SCORE_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_HOLES; i++)
            if (hits[i]) p = HOLE_PTS[i];
        return p;
    endfunction
endpackage

// File: rtl/skeeball_edge_det.sv
// skeeball_edge_det: registered rising-edge detector.
//  clk   in         system clock
//  reset in         synchronous active-high, clears the history register
//  level in  WIDTH  input levels
//  rise  out WIDTH  level & ~previous level
module skeeball_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev;
    always_ff @(posedge clk)
        prev <= reset ? '0 : level;
    assign rise = level & ~prev;
endmodule

// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl: game sequencer - coin start, ball release, scoring, game end and high score.
//  clk          in   1   system clock
//  reset        in   1   synchronous active-high
//  coin         in   1   coin level, rising edge starts a game (IDLE/DONE only)
//  hole         in   6   hole sensor levels, 10/20/30/40/50/100 points
//  gutter       in   1   gutter sensor level, rising edge scores 0
//  game         out  1   game in progress
//  ball_release out  1   one-cycle ball gate pulse
//  balls_left   out  4   balls not yet released
//  balls        out  9   thermometer of balls_left
//  score        out  10  current or last game score
//  high_score   out  10  best completed-game score
//  game_over    out  1   high while holding the end-of-game display
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int NUM_BALLS    = 9,
    parameter int ROLL_TIMEOUT = 1000,
    parameter int OVER_HOLD    = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin,
    input  logic [5:0]         hole,
    input  logic               gutter,
    output logic               game,
    output logic               ball_release,
    output logic [BALL_W-1:0]  balls_left,
    output logic [8:0]         balls,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_over
);
    localparam int CNT_MAX = ROLL_TIMEOUT > OVER_HOLD ? ROLL_TIMEOUT : OVER_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state, state_nxt;
    logic               coin_rise, gutter_rise;
    logic [5:0]         hole_rise;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] points, total;

    skeeball_edge_det #(.WIDTH(1)) u_coin   (.clk(clk), .reset(reset), .level(coin),   .rise(coin_rise));
    skeeball_edge_det #(.WIDTH(6)) u_hole   (.clk(clk), .reset(reset), .level(hole),   .rise(hole_rise));
    skeeball_edge_det #(.WIDTH(1)) u_gutter (.clk(clk), .reset(reset), .level(gutter), .rise(gutter_rise));

    assign total = score + points;

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nxt;

    always_comb begin
        state_nxt    = state;
        game         = state inside {S_ARM, S_ROLL, S_SCORE};
        ball_release = state == S_ARM;
        game_over    = state == S_DONE;
        balls        = 9'((10'd1 << balls_left) - 10'd1);
        case (state)
            S_IDLE:  state_nxt = coin_rise ? S_ARM : S_IDLE;
            S_ARM:   state_nxt = S_ROLL;
            S_ROLL:  state_nxt = (|hole_rise || gutter_rise || cnt == CNT_W'(ROLL_TIMEOUT - 1)) ? S_SCORE : S_ROLL;
            S_SCORE: state_nxt = balls_left == '0 ? S_DONE : S_ARM;
            S_DONE:  state_nxt = coin_rise ? S_ARM : cnt == CNT_W'(OVER_HOLD - 1) ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One counter serves both the ROLL timeout and the DONE hold; it is cleared on entry to each.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            points     <= '0;
            score      <= '0;
            high_score <= '0;
            balls_left <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if ((state == S_IDLE || state == S_DONE) && coin_rise) begin
                score      <= '0;
                balls_left <= BALL_W'(NUM_BALLS);
            end
            if (state == S_ARM) begin
                balls_left <= balls_left - 1'b1;
                cnt        <= '0;
            end
            // Gutter-only and timeout both land here with no hole edge, giving 0 points.
            if (state == S_ROLL)
                points <= hole_points(hole_rise);
            if (state == S_SCORE) begin
                score <= total;
                cnt   <= '0;
                if (balls_left == '0 && total > high_score)
                    high_score <= total;
            end
        end
    end
endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb_skeeball_game_ctrl: directed stimulus with a rule-level reference model and literal spot checks.
module tb_skeeball_game_ctrl;
    localparam int NB = 9, RT = 16, OH = 12;
    localparam int IDLE = 0, ARM = 1, ROLL = 2, SCORE = 3, DONE = 4;

    logic       clk = 0, reset = 1, coin = 0, gutter = 0, coin2 = 0;
    logic [5:0] hole = 0;
    logic       game, ball_release, game_over, game2, ball_release2, game_over2;
    logic [3:0] balls_left, balls_left2;
    logic [8:0] balls, balls2;
    logic [9:0] score, high_score, score2, high_score2;

    int n_checks = 0, n_errors = 0, releases = 0;
    bit chk_en = 0;

    skeeball_game_ctrl #(.NUM_BALLS(NB), .ROLL_TIMEOUT(RT), .OVER_HOLD(OH)) dut (
        .clk(clk), .reset(reset), .coin(coin), .hole(hole), .gutter(gutter),
        .game(game), .ball_release(ball_release), .balls_left(balls_left), .balls(balls),
        .score(score), .high_score(high_score), .game_over(game_over));

    skeeball_game_ctrl #(.NUM_BALLS(2), .ROLL_TIMEOUT(8), .OVER_HOLD(4)) dut2 (
        .clk(clk), .reset(reset), .coin(coin2), .hole(6'd0), .gutter(1'b0),
        .game(game2), .ball_release(ball_release2), .balls_left(balls_left2), .balls(balls2),
        .score(score2), .high_score(high_score2), .game_over(game_over2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules evaluated per clock on the sampled inputs.
    int m_st = IDLE, m_left = 0, m_score = 0, m_high = 0, m_pts = 0, m_elapsed = 0;
    logic pc = 0, pg = 0;
    logic [5:0] ph = 0;
    int pts_tbl [6] = '{10, 20, 30, 40, 50, 100};

    always @(posedge clk) begin
        logic ce, ge;
        logic [5:0] he;
        ce = coin & ~pc;
        he = hole & ~ph;
        ge = gutter & ~pg;
        if (reset) begin
            m_st = IDLE; m_left = 0; m_score = 0; m_high = 0; m_pts = 0; m_elapsed = 0;
        end else if ((m_st == IDLE || m_st == DONE) && ce) begin
            m_st = ARM; m_score = 0; m_left = NB;
        end else if (m_st == DONE) begin
            m_elapsed++;
            if (m_elapsed == OH) m_st = IDLE;
        end else if (m_st == ARM) begin
            m_left--; m_elapsed = 0; m_st = ROLL;
        end else if (m_st == ROLL) begin
            m_elapsed++;
            if (he != 0) begin
                for (int i = 5; i >= 0; i--)
                    if (he[i]) begin m_pts = pts_tbl[i]; break; end
                m_st = SCORE;
            end else if (ge || m_elapsed == RT) begin
                m_pts = 0; m_st = SCORE;
            end
        end else if (m_st == SCORE) begin
            m_score += m_pts;
            if (m_left == 0) begin
                if (m_score > m_high) m_high = m_score;
                m_elapsed = 0; m_st = DONE;
            end else m_st = ARM;
        end
        pc = reset ? 1'b0 : coin;
        ph = reset ? 6'd0 : hole;
        pg = reset ? 1'b0 : gutter;
    end

    always @(negedge clk) if (chk_en) begin
        logic [8:0] th;
        th = '0;
        for (int i = 0; i < m_left; i++) th[i] = 1'b1;
        chk("game", int'(game), int'(m_st == ARM || m_st == ROLL || m_st == SCORE));
        chk("ball_release", int'(ball_release), int'(m_st == ARM));
        chk("game_over", int'(game_over), int'(m_st == DONE));
        chk("balls_left", int'(balls_left), m_left);
        chk("balls", int'(balls), int'(th));
        chk("score", int'(score), m_score);
        chk("high_score", int'(high_score), m_high);
        if (ball_release) releases++;
    end

    task automatic wait_roll();
        int k = 0;
        while (m_st != ROLL && k < 40) begin @(negedge clk); k++; end
        chk("reach_roll", m_st, ROLL);
    endtask

    task automatic start_game();
        coin = 1;
        @(negedge clk);
        coin = 0;
        chk("start_release", int'(ball_release), 1);
    endtask

    task automatic ball(input logic [5:0] h, input logic g);
        wait_roll();
        hole = h; gutter = g;
        @(negedge clk);
        hole = 0; gutter = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_score", int'(score), 0);
        chk("rst_balls", int'(balls), 0);
        chk("rst_game", int'(game), 0);
        reset = 0;
        @(negedge clk);
        // game 1: nine 50-point balls
        start_game();
        chk("arm_balls", int'(balls), 'h1FF);
        for (int i = 0; i < 9; i++) ball(6'b010000, 1'b0);
        chk("g1_score", int'(score), 450);
        chk("g1_high", int'(high_score), 450);
        chk("g1_over", int'(game_over), 1);
        chk("g1_releases", releases, 9);
        chk("g1_balls", int'(balls), 0);
        repeat (OH) @(negedge clk);
        chk("hold_expired", int'(game_over), 0);
        chk("idle_score_kept", int'(score), 450);
        // sensor edges while idle are ignored
        hole = 6'b111111; @(negedge clk); hole = 0; gutter = 1; @(negedge clk); gutter = 0;
        @(negedge clk);
        chk("idle_sensors_game", int'(game), 0);
        chk("idle_sensors_score", int'(score), 450);
        // game 2: totals 120
        start_game();
        ball(6'b100010, 1'b0);
        chk("hole5_beats_hole1", int'(score), 100);
        ball(6'b000001, 1'b1);
        chk("hole_beats_gutter", int'(score), 110);
        wait_roll();
        coin = 1; @(negedge clk); coin = 0; @(negedge clk); coin = 1; @(negedge clk); coin = 0;
        chk("coin_in_roll_game", int'(game), 1);
        chk("coin_in_roll_rel", int'(ball_release), 0);
        chk("coin_in_roll_score", int'(score), 110);
        ball(6'b000000, 1'b1);
        chk("gutter_zero", int'(score), 110);
        wait_roll();
        repeat (RT) @(negedge clk);
        chk("timeout_score_rel", int'(ball_release), 0);
        @(negedge clk);
        chk("timeout_next_arm", int'(ball_release), 1);
        chk("timeout_score", int'(score), 110);
        ball(6'b000001, 1'b0);
        for (int i = 0; i < 4; i++) ball(6'b000000, 1'b1);
        chk("g2_score", int'(score), 120);
        chk("g2_high_kept", int'(high_score), 450);
        chk("g2_over", int'(game_over), 1);
        repeat (3) @(negedge clk);
        coin = 1;
        @(negedge clk);
        coin = 0;
        chk("done_coin_rel", int'(ball_release), 1);
        chk("done_coin_score", int'(score), 0);
        chk("done_coin_left", int'(balls_left), NB);
        chk("done_coin_over", int'(game_over), 0);
        // game 3: reach 70, then reset mid-roll
        ball(6'b001000, 1'b0);
        ball(6'b000100, 1'b0);
        chk("g3_score", int'(score), 70);
        wait_roll();
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_rst_game", int'(game), 0);
        chk("mid_rst_left", int'(balls_left), 0);
        chk("mid_rst_score", int'(score), 0);
        chk("mid_rst_high", int'(high_score), 0);
        chk("mid_rst_over", int'(game_over), 0);
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(game), 0);
        start_game();
        chk("post_rst_left", int'(balls_left), NB);
        // two-ball, eight-cycle-timeout instance, no sensors
        begin
            int g_cnt = 0, r_cnt = 0, r_last = 0, o_cnt = 0, o_first = 0;
            coin2 = 1;
            for (int i = 1; i <= 26; i++) begin
                @(negedge clk);
                coin2 = 0;
                g_cnt += int'(game2);
                if (ball_release2) begin r_cnt++; r_last = i; end
                if (game_over2) begin o_cnt++; if (o_first == 0) o_first = i; end
            end
            chk("t3_game_cycles", g_cnt, 20);
            chk("t3_releases", r_cnt, 2);
            chk("t3_second_release", r_last, 11);
            chk("t3_done_entry", o_first, 21);
            chk("t3_done_cycles", o_cnt, 4);
            chk("t3_score", int'(score2), 0);
            chk("t3_left", int'(balls_left2), 0);
        end
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
